// File: rtl/core_div_pkg.sv
// core_div_pkg: shared types and constants for the RV32M iterative divider
package core_div_pkg;
  localparam int ITER_CNT = 32;
  localparam logic [2:0] F3_DIV  = 3'h4;
  localparam logic [2:0] F3_DIVU = 3'h5;
  localparam logic [2:0] F3_REM  = 3'h6;
  localparam logic [2:0] F3_REMU = 3'h7;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/core_div_unit.sv
// core_div_unit: multi-cycle restoring divider for DIV/DIVU/REM/REMU with ready/valid on both sides
module core_div_unit
  import core_div_pkg::*;
#(
  parameter int XLEN = ITER_CNT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      resp_rd_o,
  output logic            busy_o
);
  localparam logic [5:0] ITERS = 6'(XLEN);
  state_e state_q, state_d;
  logic uns_q, uns_d, remop_q, remop_d, sa_q, sa_d, sb_q, sb_d, vld_q, vld_d;
  logic [XLEN:0] rem_q, rem_d, sh_rem;
  logic [XLEN-1:0] quo_q, quo_d, dvs_q, dvs_d, res_q, res_d, sh_quo, a_mag, b_mag, q_fin, r_fin;
  logic [5:0] cnt_q, cnt_d;
  logic [4:0] rd_q, rd_d, resp_rd_q, resp_rd_d;
  logic a_neg, b_neg, div0, ovf, ge;
  logic unused_f3;
  function automatic logic [XLEN-1:0] sfix(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction
  assign unused_f3 = funct3_i[2];
  assign req_ready_o = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign resp_valid_o = vld_q;
  assign result_o = res_q;
  assign resp_rd_o = resp_rd_q;
  always_comb begin
    a_neg = !funct3_i[0] && dividend_i[XLEN-1];
    b_neg = !funct3_i[0] && divisor_i[XLEN-1];
    a_mag = a_neg ? -dividend_i : dividend_i;
    b_mag = b_neg ? -divisor_i : divisor_i;
    div0 = divisor_i == '0;
    ovf = !funct3_i[0] && dividend_i == {1'b1, {(XLEN-1){1'b0}}} && &divisor_i;
    // remainder is one bit wider so the shifted partial remainder never overflows
    sh_rem = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    sh_quo = {quo_q[XLEN-2:0], 1'b0};
    ge = sh_rem >= {1'b0, dvs_q};
    q_fin = sfix(quo_q, !uns_q && (sa_q ^ sb_q));
    r_fin = sfix(rem_q[XLEN-1:0], !uns_q && sa_q);
    state_d = state_q;
    uns_d = uns_q;
    remop_d = remop_q;
    sa_d = sa_q;
    sb_d = sb_q;
    vld_d = vld_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    res_d = res_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    resp_rd_d = resp_rd_q;
    unique case (state_q)
      IDLE: if (req_valid_i && !flush_i) begin
        uns_d = funct3_i[0];
        remop_d = funct3_i[1];
        sa_d = a_neg;
        sb_d = b_neg;
        rd_d = rd_i;
        dvs_d = b_mag;
        quo_d = a_mag;
        rem_d = '0;
        cnt_d = '0;
        state_d = (div0 || ovf) ? DONE : CALC;
        if (div0 || ovf) begin
          vld_d = 1'b1;
          resp_rd_d = rd_i;
          res_d = div0 ? (funct3_i[1] ? dividend_i : '1) : (funct3_i[1] ? '0 : dividend_i);
        end
      end
      CALC: if (cnt_q == ITERS) begin
        state_d = DONE;
        vld_d = 1'b1;
        resp_rd_d = rd_q;
        res_d = remop_q ? r_fin : q_fin;
      end else begin
        rem_d = ge ? sh_rem - {1'b0, dvs_q} : sh_rem;
        quo_d = {sh_quo[XLEN-1:1], ge};
        cnt_d = cnt_q + 6'd1;
      end
      DONE: if (resp_ready_i) begin
        state_d = IDLE;
        vld_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      vld_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      uns_q <= 1'b0;
      remop_q <= 1'b0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      vld_q <= 1'b0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      rd_q <= '0;
      resp_rd_q <= '0;
    end else begin
      state_q <= state_d;
      uns_q <= uns_d;
      remop_q <= remop_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      vld_q <= vld_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      resp_rd_q <= resp_rd_d;
    end
  end
endmodule
